// File: rtl/stage5_control_fsm.sv
// ---------------------------------------------------------------------------
// stage5_control_fsm
// Multi-cycle control unit for the stage-5 stack datapath. One instruction
// runs as FETCH -> DECODE -> EXEC [-> WB], then returns to FETCH (Run=1) or
// parks in IDLE (Run=0). Opcode F, and opcodes 8-E when trapping is enabled,
// end in HALT until Reset.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined     : opcodes 8-E go to HALT and set the sticky Illegal flag
//   not defined : opcodes 8-E execute as NOP, Illegal is tied low
//
// State  | meaning
// INIT   | reset held / first cycle after release, pointer registers reset
// IDLE   | waiting for Run
// FETCH  | IR <= mem[PC], PC += 2
// DECODE | ValA <= top of MS, ValB <= top of RS, opcode latched
// EXEC   | opcode-specific pointer / PC update
// WB     | memory write-back for PUSHI, ALU, CALL
// HALT   | stopped until Reset
//
// Ports
//   CLK, Reset (async, active-high), Run, IR[15:0], ZeroIn    inputs
//   PC/MSP/RSP write, direction and reset strobes               outputs
//   ValAWrite, ValBWrite, IRWrite                               outputs
//   MemRead1/2, MemWrite1/2, MemDst1/2, MemData                 outputs
//   ALUOp[ALUW-1:0], Halted, Illegal                            outputs
// ---------------------------------------------------------------------------
module stage5_control_fsm #(
    parameter int OPW  = 4,
    parameter int ALUW = 3
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Run,
    input  logic [15:0]     IR,
    input  logic            ZeroIn,
    output logic            PCWrite,
    output logic            PCSource,
    output logic            PCAdd,
    output logic            PCRegReset,
    output logic            MSPWrite,
    output logic            MSPop,
    output logic            MSPRegReset,
    output logic            RSPWrite,
    output logic            RSPop,
    output logic            RSPRegReset,
    output logic            ValAWrite,
    output logic            ValBWrite,
    output logic            IRWrite,
    output logic            MemRead1,
    output logic            MemRead2,
    output logic            MemWrite1,
    output logic            MemWrite2,
    output logic [1:0]      MemDst1,
    output logic [1:0]      MemDst2,
    output logic [1:0]      MemData,
    output logic [ALUW-1:0] ALUOp,
    output logic            Halted,
    output logic            Illegal
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
    localparam logic [OPW-1:0] OP_PUSHI = OPW'(1);
    localparam logic [OPW-1:0] OP_ALU   = OPW'(2);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(3);
    localparam logic [OPW-1:0] OP_BEQZ  = OPW'(4);
    localparam logic [OPW-1:0] OP_CALL  = OPW'(5);
    localparam logic [OPW-1:0] OP_RET   = OPW'(6);
    localparam logic [OPW-1:0] OP_POP   = OPW'(7);
    localparam logic [OPW-1:0] OP_HALT  = '1;

    state_t          r_state;
    logic [OPW-1:0]  r_op;
    logic [ALUW-1:0] r_aluop;
    logic [OPW-1:0]  w_op;
    logic            w_has_wb;
    logic            w_unused_ir;

    assign w_op        = IR[15:16-OPW];
    assign w_unused_ir = ^IR[15-OPW:ALUW];
    // Only PUSHI, ALU and CALL need a memory write-back cycle.
    assign w_has_wb    = (r_op == OP_PUSHI) || (r_op == OP_ALU) || (r_op == OP_CALL);

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    assign Illegal = r_illegal;
`else
    assign Illegal = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_INIT;
            r_op      <= OP_NOP;
            r_aluop   <= '0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_INIT:   r_state <= S_IDLE;
                S_IDLE:   if (Run) r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_op <= w_op;
                    if (w_op == OP_ALU) r_aluop <= IR[ALUW-1:0];
                    if (w_op == OP_HALT) begin
                        r_state <= S_HALT;
`ifdef ILLEGAL_TRAP_EN
                    end else if (w_op > OP_POP) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
`endif
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                // Run is only looked at here, at the instruction boundary.
                S_EXEC:   r_state <= w_has_wb ? S_WB : (Run ? S_FETCH : S_IDLE);
                S_WB:     r_state <= Run ? S_FETCH : S_IDLE;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_INIT;
            endcase
        end
    end

    assign ALUOp = r_aluop;

    always_comb begin
        PCWrite = 1'b0; PCSource = 1'b0; PCAdd = 1'b0; PCRegReset = 1'b0;
        MSPWrite = 1'b0; MSPop = 1'b0; MSPRegReset = 1'b0;
        RSPWrite = 1'b0; RSPop = 1'b0; RSPRegReset = 1'b0;
        ValAWrite = 1'b0; ValBWrite = 1'b0; IRWrite = 1'b0;
        MemRead1 = 1'b0; MemRead2 = 1'b0; MemWrite1 = 1'b0; MemWrite2 = 1'b0;
        MemDst1 = 2'b00; MemDst2 = 2'b00; MemData = 2'b00;
        Halted = 1'b0;
        case (r_state)
            S_INIT: begin
                PCRegReset = 1'b1; MSPRegReset = 1'b1; RSPRegReset = 1'b1;
            end
            S_FETCH: begin
                MemRead1 = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1;
            end
            S_DECODE: begin
                MemRead1 = 1'b1; MemDst1 = 2'b01; ValAWrite = 1'b1;
                MemRead2 = 1'b1; MemDst2 = 2'b01; ValBWrite = 1'b1;
            end
            S_EXEC: begin
                case (r_op)
                    OP_PUSHI: begin MSPWrite = 1'b1; MSPop = 1'b1; end
                    OP_ALU:   MSPWrite = 1'b1;
                    OP_JMP:   begin PCWrite = 1'b1; PCAdd = 1'b1; end
                    OP_BEQZ: begin
                        // Branch taken is the only Mealy output.
                        MSPWrite = 1'b1;
                        PCWrite  = ZeroIn;
                        PCAdd    = ZeroIn;
                    end
                    OP_CALL:  begin RSPWrite = 1'b1; RSPop = 1'b1; end
                    OP_RET:   begin PCWrite = 1'b1; PCSource = 1'b1; RSPWrite = 1'b1; end
                    OP_POP:   MSPWrite = 1'b1;
                    default:  ;
                endcase
            end
            S_WB: begin
                case (r_op)
                    OP_PUSHI: begin MemWrite1 = 1'b1; MemDst1 = 2'b01; MemData = 2'b10; end
                    OP_ALU:   begin MemWrite1 = 1'b1; MemDst1 = 2'b01; MemData = 2'b01; end
                    OP_CALL: begin
                        MemWrite2 = 1'b1; MemDst2 = 2'b01; MemData = 2'b00;
                        PCWrite   = 1'b1; PCAdd   = 1'b1;
                    end
                    default:  ;
                endcase
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

endmodule
